// File: rtl/coherent_avg_pkg.sv
// Shared types and default sizing for the coherent averager.
package coherent_avg_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    ACCUM     = 2'd2,
    OUTPUT    = 2'd3
  } state_e;

  localparam int DEF_DATA_W   = 14;
  localparam int DEF_N_POINTS = 128;
  localparam int DEF_M_LOG2   = 7;

endpackage

// File: rtl/avg_acc_ram.sv
// Simple dual-port accumulator RAM: one write port, one registered read port.
module avg_acc_ram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 21,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // No reset so the array maps onto block memory; the first period overwrites it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/coherent_averager.sv
// Coherent period averager: sums 2^M_LOG2 periods in RAM, then streams the mean.
// Optional period-marker checking is enabled with COHERENT_AVG_SYNC_CHECK_EN.
module coherent_averager
  import coherent_avg_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int N_POINTS = DEF_N_POINTS,
  parameter int M_LOG2   = DEF_M_LOG2,
  parameter int IDX_W    = $clog2(N_POINTS),
  parameter int ACC_W    = DATA_W + M_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              period_start,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic [IDX_W-1:0]  avg_index,
  output logic              frame_done,
  output logic              busy,
  output logic              sync_err
);

  localparam logic [IDX_W:0] OC_LAST = (IDX_W+1)'(N_POINTS + 1);
  localparam logic [IDX_W:0] OC_MAX  = (IDX_W+1)'(N_POINTS);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [M_LOG2-1:0]   per_cnt_q, per_cnt_d;
  logic [IDX_W:0]      oc_q, oc_d;
  logic                p_vld_q, p_vld_d;
  logic                p_first_q, p_first_d;
  logic [IDX_W-1:0]    p_addr_q, p_addr_d;
  logic [DATA_W-1:0]   p_data_q, p_data_d;
  logic                avg_valid_q, avg_valid_d;
  logic [IDX_W-1:0]    avg_index_q, avg_index_d;
  logic                frame_done_q, frame_done_d;
  logic                ram_re;
  logic [IDX_W-1:0]    ram_raddr;
  logic [ACC_W-1:0]    ram_rdata, ram_wdata;
  logic                resync, sample_ok, last_sample;

  assign sample_ok   = (state_q == ACCUM) && data_valid && !resync;
  assign last_sample = sample_ok && (&idx_q) && (&per_cnt_q);

`ifdef COHERENT_AVG_SYNC_CHECK_EN
  logic sync_err_q, sync_err_d;
  logic idx0_miss;

  assign resync    = (state_q == ACCUM) && data_valid && period_start && (idx_q != '0);
  assign idx0_miss = (state_q == ACCUM) && data_valid && !period_start && (idx_q == '0);

  always_comb begin
    sync_err_d = sync_err_q;
    if (resync || idx0_miss) sync_err_d = 1'b1;
    if (!enable)             sync_err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_err_q <= 1'b0;
    else       sync_err_q <= sync_err_d;
  end

  assign sync_err = sync_err_q;
`else
  assign resync   = 1'b0;
  assign sync_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = WAIT_SYNC;
      WAIT_SYNC: if (data_valid && period_start) state_d = ACCUM;
      ACCUM:     if (last_sample) state_d = OUTPUT;
      OUTPUT:    if (oc_q == OC_LAST) state_d = WAIT_SYNC;
      default:   state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // Datapath / outputs: stage 0 accepts a sample and issues the read,
  // stage 1 (p_*_q) adds it to the returned word and writes back.
  always_comb begin
    idx_d        = idx_q;
    per_cnt_d    = per_cnt_q;
    oc_d         = oc_q;
    p_vld_d      = 1'b0;
    p_first_d    = p_first_q;
    p_addr_d     = p_addr_q;
    p_data_d     = p_data_q;
    ram_re       = 1'b0;
    ram_raddr    = idx_q;
    avg_valid_d  = 1'b0;
    avg_index_d  = avg_index_q;
    frame_done_d = 1'b0;

    case (state_q)
      WAIT_SYNC: begin
        if (data_valid && period_start) begin
          p_vld_d   = 1'b1;
          p_first_d = 1'b1;
          p_addr_d  = '0;
          p_data_d  = data_in;
          idx_d     = IDX_W'(1);
          per_cnt_d = '0;
        end
      end
      ACCUM: begin
        oc_d = '0;
        if (resync) begin
          p_vld_d   = 1'b1;
          p_first_d = 1'b1;
          p_addr_d  = '0;
          p_data_d  = data_in;
          idx_d     = IDX_W'(1);
          per_cnt_d = '0;
        end else if (data_valid) begin
          p_vld_d   = 1'b1;
          p_first_d = (per_cnt_q == '0);
          p_addr_d  = idx_q;
          p_data_d  = data_in;
          ram_re    = (per_cnt_q != '0);
          ram_raddr = idx_q;
          idx_d     = idx_q + 1'b1;
          if (&idx_q) per_cnt_d = per_cnt_q + 1'b1;
        end
      end
      OUTPUT: begin
        oc_d = oc_q + 1'b1;
        // oc 0 lets the final write land; reads cover oc 1..N_POINTS
        if (oc_q != '0 && oc_q <= OC_MAX) begin
          ram_re      = 1'b1;
          ram_raddr   = oc_q[IDX_W-1:0] - 1'b1;
          avg_valid_d = 1'b1;
          avg_index_d = oc_q[IDX_W-1:0] - 1'b1;
        end
        if (oc_q == OC_LAST) frame_done_d = 1'b1;
      end
      default: ;
    endcase

    if (!enable) begin
      idx_d        = '0;
      per_cnt_d    = '0;
      oc_d         = '0;
      p_vld_d      = 1'b0;
      avg_valid_d  = 1'b0;
      avg_index_d  = '0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q        <= '0;
      per_cnt_q    <= '0;
      oc_q         <= '0;
      p_vld_q      <= 1'b0;
      p_first_q    <= 1'b0;
      p_addr_q     <= '0;
      p_data_q     <= '0;
      avg_valid_q  <= 1'b0;
      avg_index_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      per_cnt_q    <= per_cnt_d;
      oc_q         <= oc_d;
      p_vld_q      <= p_vld_d;
      p_first_q    <= p_first_d;
      p_addr_q     <= p_addr_d;
      p_data_q     <= p_data_d;
      avg_valid_q  <= avg_valid_d;
      avg_index_q  <= avg_index_d;
      frame_done_q <= frame_done_d;
    end
  end

  // First period ignores the stale RAM word instead of reading it.
  assign ram_wdata = (p_first_q ? '0 : ram_rdata) + {{M_LOG2{p_data_q[DATA_W-1]}}, p_data_q};

  avg_acc_ram #(
    .DEPTH(N_POINTS),
    .WIDTH(ACC_W)
  ) u_ram (
    .clk  (clk),
    .we   (p_vld_q),
    .waddr(p_addr_q),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // Dropping the low M_LOG2 bits is the floor-rounded arithmetic shift.
  assign avg_out    = avg_valid_q ? ram_rdata[ACC_W-1:M_LOG2] : '0;
  assign avg_valid  = avg_valid_q;
  assign avg_index  = avg_index_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == ACCUM) || (state_q == OUTPUT);

endmodule
